fpu_status_collector: RTL and testbench
=======================================

Name: fpu_status_collector

Overview:
Multi-channel successor to the single-lane FPU_out status bundle. It captures per-result exception flags from N_CH FPU lanes when each lane asserts its per-channel ready. Captured records are arbitrated round-robin into one FIFO and presented on a valid/ready output stream. It also keeps IEEE-style sticky exception flags with a maskable interrupt and a saturating drop counter. The block sits between the FPU lanes and the status/CSR logic.

Parameters:
N_CH, 4, number of FPU result lanes (1..16)
DEPTH, 8, record FIFO depth (power of 2, >=2)
CNT_W, 8, drop counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_ready  in  N_CH  per-lane result-valid pulse (FPU_out ready)
in_flags  in  8*N_CH  lane i at [8i+7:8i]; bit0 ine, 1 overflow, 2 underflow, 3 div_zero, 4 inf, 5 zero, 6 qnan, 7 snan
ch_busy  out  N_CH  lane holding register occupied
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_ch  out  $clog2(N_CH) (min 1)  lane id of head record
out_flags  out  8  flags of head record
fifo_count  out  $clog2(DEPTH)+1  current occupancy
sticky_flags  out  8  OR of all accepted flags since last clear
sticky_ovr  out  1  a lane event was dropped since last clear
clear_sticky  in  1  pulse: clear sticky_flags, sticky_ovr, drop_cnt
irq_mask  in  8  1 = flag masked from irq
irq  out  1  registered interrupt
drop_cnt  out  CNT_W  saturating count of dropped lane events

Behaviour:
- Reset: clk and rst are the only clock/reset. Asynchronous, active-low: rst=0 immediately clears all registers.
- Values while in reset: hold_valid=0, ch_busy=0, FIFO empty, out_valid=0, out_ch=0, out_flags=0, fifo_count=0, sticky_flags=0, sticky_ovr=0, irq=0, drop_cnt=0, RR pointer=0.
- Holding stage: one register per lane.
- Lane acceptance: at an edge with in_ready[i]=1, the lane accepts (hold<=in_flags[i], hold_valid<=1) if hold_valid[i]=0 or lane i is granted at that same edge.
- Otherwise the event is dropped: drop_cnt+1 (saturates at 2^CNT_W-1), sticky_ovr<=1, flags discarded.
- ch_busy[i] = hold_valid[i], registered.
- Arbiter: each edge, if FIFO can be written (fifo_count<DEPTH, or a pop occurs at the same edge), grant one lane with hold_valid=1.
- Grant search is round-robin, starting at the RR pointer. The RR pointer then moves to granted lane+1, mod N_CH.
- The granted record {i, hold[i]} is written to the FIFO and hold_valid[i]<=0, unless a new accept at the same edge reloads it.
- No grant occurs when the FIFO is full and no pop happens.
- Latency: in_ready sampled at edge E0 gives out_valid=1 after E1 at the earliest (2 cycles). The FIFO is first-word-fall-through.
- Output: a pop happens at an edge with out_valid & out_ready. out_ch/out_flags hold steady while out_valid=1 and out_ready=0.
- With no pop, out_ch/out_flags hold their last value.
- fifo_count: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop. It never exceeds DEPTH and never underflows.
- Sticky flags are set at the acceptance edge by OR of the flags of all accepting lanes.
- Simultaneous clear_sticky and a new acceptance: register <= new flags, so new sets win. Same rule for sticky_ovr and drop_cnt, which becomes 1 if a drop coincides with clear.
- irq <= |(sticky_flags_next & ~irq_mask), registered. A mask change takes effect on the next edge.
- Reset mid-operation: all in-flight records are discarded; there is no partial pop.

Test Plan:
- Single event: lane 2 in_ready with flags 8'h03 -> two cycles later out_valid=1, out_ch=2, out_flags=03. sticky_flags=03. With irq_mask=0, irq=1 one edge after acceptance.
- Round-robin: all 4 lanes pulse the same cycle with distinct flags, out_ready=1 -> records pop in order lanes 0,1,2,3. A second simultaneous burst pops in order 0,1,2,3 again (RR pointer at 0).
- Backpressure: DEPTH=8, out_ready=0, lane 0 pulses 10 consecutive cycles -> 8 records in FIFO, 1 in hold. The last pulse is dropped: drop_cnt=1, sticky_ovr=1, fifo_count=8.
- Full with pop: FIFO full, out_ready=1 and a hold pending -> fifo_count stays 8 and the hold record is written in the same cycle.
- Clear vs set: clear_sticky coincides with a lane 1 accept of 8'h80 -> sticky_flags=80. With irq_mask=8'h80, irq=0.
- Async reset: assert rst=0 mid-burst, between edges -> outputs zero immediately. After release, the first event latency is 2 cycles.

Source files
------------

// File: rtl/fpu_status_collector.sv
// Collects per-lane FPU exception flags, arbitrates them round-robin into a FWFT record FIFO, keeps sticky flags/irq/drop count.
// Latency: in_ready at edge E0 -> out_valid after E1 (2 cycles minimum).
// Backpressure: out_ready low fills the FIFO, then lane holding registers; a lane event arriving on an occupied, ungranted lane is dropped and counted.
module fpu_status_collector #(
    parameter int N_CH  = 4,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   in_ready,
    input  logic [8*N_CH-1:0] in_flags,
    output logic [N_CH-1:0]   ch_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [7:0]        out_flags,
    output logic [CW-1:0]     fifo_count,
    output logic [7:0]        sticky_flags,
    output logic              sticky_ovr,
    input  logic              clear_sticky,
    input  logic [7:0]        irq_mask,
    output logic              irq,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam int DW = $clog2(N_CH + 1);

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [7:0]      flags;
    } rec_t;

    logic [7:0]      hold [N_CH];
    logic [N_CH-1:0] hold_valid;
    logic [CH_W-1:0] rr_ptr;
    rec_t            mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;

    logic            pop, can_write, grant_vld;
    logic [CH_W-1:0] grant_idx;
    int              idx;
    logic [N_CH-1:0] acc;
    logic [7:0]      acc_flags;
    logic [DW-1:0]   ndrop;
    rec_t            wr_rec;
    logic [AW-1:0]   rd_ptr_nxt;
    logic [CW-1:0]   count_nxt;
    logic [7:0]      sticky_nxt;
    logic [CNT_W+DW-1:0] cnt_sum;

    assign pop       = out_valid & out_ready;
    assign can_write = (fifo_count < CW'(DEPTH)) | pop;
    assign out_valid = (fifo_count != '0);
    assign ch_busy   = hold_valid;

    // Round-robin search starting at rr_ptr; first occupied lane wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(rr_ptr) + k) % N_CH;
            if (!grant_vld && can_write && hold_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
    end

    // A busy lane may still accept when it is being drained this very edge.
    always_comb begin
        acc       = '0;
        acc_flags = '0;
        ndrop     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (in_ready[i]) begin
                if (!hold_valid[i] || (grant_vld && grant_idx == CH_W'(i))) begin
                    acc[i]    = 1'b1;
                    acc_flags = acc_flags | in_flags[8*i +: 8];
                end else begin
                    ndrop = ndrop + DW'(1);
                end
            end
        end
    end

    always_comb begin
        wr_rec       = '0;
        wr_rec.ch    = grant_idx;
        wr_rec.flags = hold[grant_idx];
        rd_ptr_nxt   = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt    = fifo_count;
        if (grant_vld && !pop)
            count_nxt = fifo_count + CW'(1);
        else if (!grant_vld && pop)
            count_nxt = fifo_count - CW'(1);
        sticky_nxt = (clear_sticky ? 8'h00 : sticky_flags) | acc_flags;
        cnt_sum    = (clear_sticky ? '0 : {{DW{1'b0}}, drop_cnt}) + {{CNT_W{1'b0}}, ndrop};
    end

    always_ff @(posedge clk) begin
        if (grant_vld)
            mem[wr_ptr] <= wr_rec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) hold[i] <= '0;
            hold_valid   <= '0;
            rr_ptr       <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_count   <= '0;
            out_ch       <= '0;
            out_flags    <= '0;
            sticky_flags <= '0;
            sticky_ovr   <= 1'b0;
            drop_cnt     <= '0;
            irq          <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (acc[i]) begin
                    hold[i]       <= in_flags[8*i +: 8];
                    hold_valid[i] <= 1'b1;
                end else if (grant_vld && grant_idx == CH_W'(i)) begin
                    hold_valid[i] <= 1'b0;
                end
            end
            if (grant_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
                rr_ptr <= (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + CH_W'(1);
            end
            rd_ptr     <= rd_ptr_nxt;
            fifo_count <= count_nxt;
            // Head register: the incoming record bypasses memory when it becomes the head.
            if (count_nxt != '0) begin
                if (grant_vld && rd_ptr_nxt == wr_ptr) begin
                    out_ch    <= wr_rec.ch;
                    out_flags <= wr_rec.flags;
                end else begin
                    out_ch    <= mem[rd_ptr_nxt].ch;
                    out_flags <= mem[rd_ptr_nxt].flags;
                end
            end
            sticky_flags <= sticky_nxt;
            sticky_ovr   <= (clear_sticky ? 1'b0 : sticky_ovr) | (ndrop != '0);
            drop_cnt     <= (cnt_sum > {{DW{1'b0}}, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
            irq          <= |(sticky_nxt & ~irq_mask);
        end
    end
endmodule

// File: tb/tb_fpu_status_collector.sv
// Randomized and directed bench for fpu_status_collector against a queue-based reference model.
module tb_fpu_status_collector;
    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   in_ready = '0;
    logic [8*N-1:0] in_flags = '0;
    logic [N-1:0]   ch_busy;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [1:0]     out_ch;
    logic [7:0]     out_flags;
    logic [3:0]     fifo_count;
    logic [7:0]     sticky_flags;
    logic           sticky_ovr;
    logic           clear_sticky = 1'b0;
    logic [7:0]     irq_mask = '0;
    logic           irq;
    logic [CNT_W-1:0] drop_cnt;

    int checks = 0;
    int passed = 0;

    fpu_status_collector #(.N_CH(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_ready(in_ready), .in_flags(in_flags),
        .ch_busy(ch_busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_flags(out_flags), .fifo_count(fifo_count),
        .sticky_flags(sticky_flags), .sticky_ovr(sticky_ovr),
        .clear_sticky(clear_sticky), .irq_mask(irq_mask), .irq(irq),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic [7:0] f;
    } rec_t;

    rec_t       m_q[$];
    logic [7:0] m_hold [N];
    bit [N-1:0] m_hv;
    int         m_rr, m_cnt, m_out_ch;
    logic [7:0] m_sticky, m_out_f;
    bit         m_ovr, m_irq;

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < N; i++) m_hold[i] = '0;
        m_hv = '0; m_rr = 0; m_cnt = 0; m_out_ch = 0;
        m_sticky = '0; m_out_f = '0; m_ovr = 0; m_irq = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge, then the DUT.
    task automatic step();
        int grant, nd;
        bit pop, canw;
        bit [N-1:0] hv_old;
        logic [7:0] accf;
        rec_t r;
        pop   = (m_q.size() > 0) && out_ready;
        canw  = (m_q.size() < DEPTH) || pop;
        grant = -1;
        if (canw)
            for (int k = 0; k < N; k++)
                if (grant < 0 && m_hv[(m_rr + k) % N]) grant = (m_rr + k) % N;
        hv_old = m_hv;
        if (pop) void'(m_q.pop_front());
        if (grant >= 0) begin
            r.ch = grant; r.f = m_hold[grant];
            m_q.push_back(r);
            m_hv[grant] = 0;
            m_rr = (grant + 1) % N;
        end
        accf = '0; nd = 0;
        for (int i = 0; i < N; i++)
            if (in_ready[i]) begin
                if (!hv_old[i] || grant == i) begin
                    m_hold[i] = in_flags[8*i +: 8];
                    m_hv[i]   = 1;
                    accf      = accf | in_flags[8*i +: 8];
                end else nd++;
            end
        if (clear_sticky) begin m_sticky = '0; m_ovr = 0; m_cnt = 0; end
        m_sticky = m_sticky | accf;
        if (nd > 0) m_ovr = 1;
        m_cnt = (m_cnt + nd > 255) ? 255 : m_cnt + nd;
        m_irq = |(m_sticky & ~irq_mask);
        if (m_q.size() > 0) begin m_out_ch = m_q[0].ch; m_out_f = m_q[0].f; end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [36:0] model_vec();
        return {m_q.size() > 0, 2'(m_out_ch), m_out_f, 4'(m_q.size()), m_hv,
                m_sticky, m_ovr, m_irq, 8'(m_cnt)};
    endfunction

    function automatic logic [36:0] dut_vec();
        return {out_valid, out_ch, out_flags, fifo_count, ch_busy,
                sticky_flags, sticky_ovr, irq, drop_cnt};
    endfunction

    task automatic do_reset();
        in_ready = '0; in_flags = '0; out_ready = 0; clear_sticky = 0; irq_mask = '0;
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        #1;
        checks++;
        if (dut_vec() !== 37'd0) $display("FAIL reset_in: got %h want 0", dut_vec()); else passed++;
        do_reset();
        step();
        checks++;
        if (dut_vec() !== 37'd0) $display("FAIL reset_idle: got %h want 0", dut_vec()); else passed++;
    endtask

    task automatic test_single_event();
        do_reset();
        in_ready = 4'b0100; in_flags = 32'h0003_0000;
        step();
        in_ready = '0; in_flags = '0;
        checks++;
        if (out_valid !== 1'b0 || ch_busy !== 4'b0100) $display("FAIL single_e0: got v=%b busy=%b want v=0 busy=0100", out_valid, ch_busy); else passed++;
        checks++;
        if (sticky_flags !== 8'h03 || irq !== 1'b1) $display("FAIL single_sticky: got %h irq=%b want 03 irq=1", sticky_flags, irq); else passed++;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_flags !== 8'h03) $display("FAIL single_out: got v=%b ch=%0d f=%h want v=1 ch=2 f=03", out_valid, out_ch, out_flags); else passed++;
    endtask

    task automatic test_round_robin();
        int got[$];
        do_reset();
        out_ready = 1;
        for (int b = 0; b < 2; b++) begin
            got.delete();
            in_ready = 4'hF; in_flags = 32'h8844_2211;
            step();
            in_ready = '0;
            for (int c = 0; c < 8; c++) begin
                if (out_valid && out_ready) got.push_back(int'(out_ch));
                step();
            end
            checks++;
            if (got.size() != 4) $display("FAIL rr_count: got %0d want 4", got.size());
            else if (got[0] != 0 || got[1] != 1 || got[2] != 2 || got[3] != 3)
                $display("FAIL rr_order: got %0d%0d%0d%0d want 0123", got[0], got[1], got[2], got[3]);
            else passed++;
        end
        checks++;
        if (dut_vec() !== model_vec()) $display("FAIL rr_model: got %h want %h", dut_vec(), model_vec()); else passed++;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 0;
        for (int p = 1; p <= 10; p++) begin
            in_ready = 4'b0001; in_flags = 32'(p);
            step();
        end
        in_ready = '0;
        checks++;
        if (fifo_count !== 4'd8 || ch_busy !== 4'b0001) $display("FAIL bp_fill: got cnt=%0d busy=%b want 8 0001", fifo_count, ch_busy); else passed++;
        checks++;
        if (drop_cnt !== 8'd1 || sticky_ovr !== 1'b1) $display("FAIL bp_drop: got drop=%0d ovr=%b want 1 1", drop_cnt, sticky_ovr); else passed++;
        checks++;
        if (out_flags !== 8'h01) $display("FAIL bp_head: got %h want 01", out_flags); else passed++;
    endtask

    task automatic test_full_with_pop();
        out_ready = 1;
        step();
        out_ready = 0;
        checks++;
        if (fifo_count !== 4'd8 || ch_busy !== 4'b0000) $display("FAIL fullpop_cnt: got cnt=%0d busy=%b want 8 0000", fifo_count, ch_busy); else passed++;
        checks++;
        if (out_flags !== 8'h02) $display("FAIL fullpop_head: got %h want 02", out_flags); else passed++;
        checks++;
        if (dut_vec() !== model_vec()) $display("FAIL fullpop_model: got %h want %h", dut_vec(), model_vec()); else passed++;
    endtask

    task automatic test_clear_vs_set();
        do_reset();
        irq_mask = 8'h80;
        in_ready = 4'b0001; in_flags = 32'h0000_0001;
        step();
        checks++;
        if (irq !== 1'b1 || sticky_flags !== 8'h01) $display("FAIL clr_pre: got irq=%b st=%h want 1 01", irq, sticky_flags); else passed++;
        clear_sticky = 1; in_ready = 4'b0010; in_flags = 32'h0000_8000;
        step();
        clear_sticky = 0; in_ready = '0;
        checks++;
        if (sticky_flags !== 8'h80 || irq !== 1'b0) $display("FAIL clr_set: got st=%h irq=%b want 80 0", sticky_flags, irq); else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        in_ready = 4'hF; in_flags = $urandom() | 32'h0101_0101;
        step();
        in_ready = '0;
        step();
        #2;
        rst = 0;
        #1;
        checks++;
        if (dut_vec() !== 37'd0) $display("FAIL arst_now: got %h want 0", dut_vec()); else passed++;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
        in_ready = 4'b1000; in_flags = 32'h1000_0000;
        step();
        in_ready = '0;
        checks++;
        if (out_valid !== 1'b0 || ch_busy !== 4'b1000) $display("FAIL arst_e0: got v=%b busy=%b want 0 1000", out_valid, ch_busy); else passed++;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_flags !== 8'h10) $display("FAIL arst_e1: got v=%b ch=%0d f=%h want 1 3 10", out_valid, out_ch, out_flags); else passed++;
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) in_ready[i] = ($urandom_range(0, 2) == 0);
            in_flags     = $urandom();
            out_ready    = (c % 100 < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
            clear_sticky = ($urandom_range(0, 30) == 0);
            if (c % 50 == 0) irq_mask = 8'($urandom());
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errs++;
                if (errs < 10) $display("FAIL random_c%0d: got %h want %h", c, dut_vec(), model_vec());
            end else passed++;
        end
        in_ready = '0; clear_sticky = 0;
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_round_robin();
        test_backpressure();
        test_full_with_pop();
        test_clear_vs_set();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
